// File: rtl/l1_dcache_assoc_if.sv
// Pipeline-side (p1_*) and line-memory-side (mem_*) signals of l1_dcache_assoc.
// The cache uses the slave modport; the CPU/memory environment uses master.
interface l1_dcache_assoc_if #(
    parameter int LINE_BITS = 256
);
    logic [31:0]          p1_addr_i;
    logic                 p1_read_i;
    logic                 p1_write_i;
    logic [31:0]          p1_data_i;
    logic [31:0]          p1_data_o;
    logic                 p1_stall_o;
    logic [31:0]          mem_addr_o;
    logic [LINE_BITS-1:0] mem_data_o;
    logic [LINE_BITS-1:0] mem_data_i;
    logic                 mem_enable_o;
    logic                 mem_write_o;
    logic                 mem_ack_i;

    modport slave (
        input  p1_addr_i, p1_read_i, p1_write_i, p1_data_i, mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

    modport master (
        output p1_addr_i, p1_read_i, p1_write_i, p1_data_i, mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );
endinterface

// File: rtl/l1_dcache_assoc.sv
// Write-back, write-allocate set-associative L1 data cache (WAYS 1|2, per-set LRU).
// Define L1_DCACHE_PERF_CNT_EN to add saturating hit/miss counter outputs.
module l1_dcache_assoc #(
    parameter int WAYS      = 2,
    parameter int SETS      = 32,
    parameter int LINE_BITS = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    l1_dcache_assoc_if.slave         bus
`ifdef L1_DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]              hit_cnt_o,
    output logic [31:0]              miss_cnt_o
`endif
);
    localparam int OFF  = $clog2(LINE_BITS / 8);
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 32 - OFF - IDX;
    localparam int WSEL = OFF - 2;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WBACK, ALLOC, REFILL} state_t;
    state_t state_q, state_d;

    logic [TAGW-1:0]      tag_q   [WAYS][SETS];
    logic [LINE_BITS-1:0] data_q  [WAYS][SETS];
    logic                 valid_q [WAYS][SETS];
    logic                 dirty_q [WAYS][SETS];
    logic [SETS-1:0]      lru_q;

    logic [TAGW-1:0]      req_tag;
    logic [IDX-1:0]       req_idx;
    logic [WSEL-1:0]      req_word;
    logic                 req;
    logic                 hit;
    logic [WW-1:0]        hit_way;
    logic [WW-1:0]        victim;
    logic [LINE_BITS-1:0] hit_line;
    logic                 idle_hit;
    logic                 rd_hit;
    logic                 wr_hit;
    logic                 miss_start;
    logic                 unused_addr_lsb;

    logic [TAGW-1:0]      miss_tag_q;
    logic [IDX-1:0]       miss_idx_q;
    logic [WW-1:0]        victim_q;
    logic [LINE_BITS-1:0] refill_q;

    assign req_tag         = bus.p1_addr_i[31 -: TAGW];
    assign req_idx         = bus.p1_addr_i[OFF +: IDX];
    assign req_word        = bus.p1_addr_i[2 +: WSEL];
    assign unused_addr_lsb = ^bus.p1_addr_i[1:0];
    assign req             = bus.p1_read_i | bus.p1_write_i;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Invalid way first (way 0 preferred), otherwise the set's LRU way.
    always_comb begin
        victim = '0;
        if (WAYS > 1) begin
            if (!valid_q[0][req_idx])
                victim = '0;
            else if (!valid_q[WAYS-1][req_idx])
                victim = WW'(WAYS - 1);
            else
                victim = WW'(lru_q[req_idx]);
        end
    end

    assign hit_line = data_q[hit_way][req_idx];
    assign idle_hit = (state_q == IDLE) && req && hit;
    assign wr_hit   = idle_hit && bus.p1_write_i;
    assign rd_hit   = idle_hit && !bus.p1_write_i;

    assign bus.p1_data_o  = rd_hit ? hit_line[{req_word, 5'd0} +: 32] : '0;
    assign bus.p1_stall_o = ((state_q == IDLE) && req && !hit) || (state_q != IDLE);

    always_comb begin
        state_d          = state_q;
        miss_start       = 1'b0;
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_data_o   = '0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    miss_start = 1'b1;
                    if (valid_q[victim][req_idx] && dirty_q[victim][req_idx])
                        state_d = WBACK;
                    else
                        state_d = ALLOC;
                end
            end
            WBACK: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = {tag_q[victim_q][miss_idx_q], miss_idx_q, {OFF{1'b0}}};
                bus.mem_data_o   = data_q[victim_q][miss_idx_q];
                if (bus.mem_ack_i)
                    state_d = ALLOC;
            end
            ALLOC: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_addr_o   = {miss_tag_q, miss_idx_q, {OFF{1'b0}}};
                if (bus.mem_ack_i)
                    state_d = REFILL;
            end
            REFILL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Miss context is latched so the sequence completes even if the request drops.
    always_ff @(posedge clk) begin
        if (miss_start) begin
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
            victim_q   <= victim;
        end
        if ((state_q == ALLOC) && bus.mem_ack_i)
            refill_q <= bus.mem_data_i;
        if (state_q == REFILL) begin
            data_q[victim_q][miss_idx_q] <= refill_q;
            tag_q[victim_q][miss_idx_q]  <= miss_tag_q;
        end else if (wr_hit) begin
            data_q[hit_way][req_idx][{req_word, 5'd0} +: 32] <= bus.p1_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
            lru_q <= '0;
        end else if (state_q == REFILL) begin
            valid_q[victim_q][miss_idx_q] <= 1'b1;
            dirty_q[victim_q][miss_idx_q] <= 1'b0;
            lru_q[miss_idx_q]             <= ~victim_q[0];
        end else if (idle_hit) begin
            lru_q[req_idx] <= ~hit_way[0];
            if (bus.p1_write_i)
                dirty_q[hit_way][req_idx] <= 1'b1;
        end
    end

`ifdef L1_DCACHE_PERF_CNT_EN
    // The first IDLE cycle after REFILL is the replayed request, not a fresh hit.
    logic replay_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            replay_q   <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            replay_q <= (state_q == REFILL);
            if (miss_start && (miss_cnt_o != '1))
                miss_cnt_o <= miss_cnt_o + 32'd1;
            if (idle_hit && !replay_q && (hit_cnt_o != '1))
                hit_cnt_o <= hit_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_l1_dcache_assoc.sv
// Scoreboard bench for l1_dcache_assoc: expected load data is queued at issue and
// checked at completion; a line-memory model answers write-backs and refills.
module tb_l1_dcache_assoc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l1_dcache_assoc_if #(.LINE_BITS(256)) bus ();

`ifdef L1_DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    l1_dcache_assoc #(.WAYS(2), .SETS(32), .LINE_BITS(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef L1_DCACHE_PERF_CNT_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    typedef struct packed {
        logic         w;
        logic [31:0]  a;
        logic [255:0] d;
    } txn_t;

    int unsigned  tests_run    = 0;
    int unsigned  tests_failed = 0;
    logic [255:0] mem_model [logic [31:0]];
    logic [31:0]  golden    [logic [31:0]];
    logic [31:0]  exp_q     [$];
    txn_t         txq       [$];
    int           acc_stall;
    logic         acc_first_stall;
    logic [31:0]  acc_rdata;
    int           acc_idle_bad = 0;

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem_model.exists(la)) return mem_model[la];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = {la[23:0], 8'(i)} ^ 32'h5A00_0000;
        return l;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  wa;
        wa = {a[31:2], 2'b00};
        if (golden.exists(wa)) return golden[wa];
        l = mem_line({a[31:5], 5'b0});
        return l[{a[4:2], 5'b0} +: 32];
    endfunction

    task automatic drive_idle();
        bus.p1_addr_i  = '0;
        bus.p1_read_i  = 1'b0;
        bus.p1_write_i = 1'b0;
        bus.p1_data_i  = '0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        golden.delete();
    endtask

    // One CPU access held until the stall drops; memory acks after 'lat' cycles.
    task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] wd, input int lat);
        int   cnt;
        logic prev_en;
        logic cur_w;
        cnt       = 0;
        prev_en   = 1'b0;
        cur_w     = 1'b0;
        acc_stall = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            bus.mem_ack_i  = 1'b0;
            bus.p1_addr_i  = a;
            bus.p1_read_i  = rd;
            bus.p1_write_i = wr;
            bus.p1_data_i  = wd;
            #1;
            if (cyc == 0) acc_first_stall = bus.p1_stall_o;
            if (!bus.mem_enable_o && (bus.mem_write_o !== 1'b0 || bus.mem_addr_o !== '0 ||
                                      bus.mem_data_o !== '0))
                acc_idle_bad++;
            if (bus.p1_stall_o === 1'b0) begin
                acc_rdata = bus.p1_data_o;
                if (wr) golden[{a[31:2], 2'b00}] = wd;
                return;
            end
            acc_stall++;
            if (bus.mem_enable_o) begin
                if (!prev_en || cur_w != bus.mem_write_o) cnt = 0;
                prev_en = 1'b1;
                cur_w   = bus.mem_write_o;
                cnt++;
                if (cnt >= lat) begin
                    bus.mem_ack_i = 1'b1;
                    if (bus.mem_write_o) begin
                        mem_model[bus.mem_addr_o] = bus.mem_data_o;
                        txq.push_back('{1'b1, bus.mem_addr_o, bus.mem_data_o});
                    end else begin
                        bus.mem_data_i = mem_line(bus.mem_addr_o);
                        txq.push_back('{1'b0, bus.mem_addr_o, bus.mem_data_i});
                    end
                    cnt     = 0;
                    prev_en = 1'b0;
                end
            end else begin
                prev_en = 1'b0;
            end
        end
        tests_run++;
        tests_failed++;
        $display("FAIL access_timeout addr=%h stall still %b after 200 cycles", a, bus.p1_stall_o);
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (bus.mem_enable_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset_hold_enable got %b want 0", bus.mem_enable_o);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.p1_stall_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset_stall got %b want 0", bus.p1_stall_o);
        end
        tests_run++;
        if (bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mem_ctrl got en=%b wr=%b want 0/0", bus.mem_enable_o, bus.mem_write_o);
        end
        tests_run++;
        if (bus.mem_addr_o !== '0 || bus.mem_data_o !== '0) begin
            tests_failed++; $display("FAIL reset_mem_bus got addr=%h want 0", bus.mem_addr_o);
        end
        tests_run++;
        if (bus.p1_data_o !== '0) begin
            tests_failed++; $display("FAIL reset_p1_data got %h want 0", bus.p1_data_o);
        end
`ifdef L1_DCACHE_PERF_CNT_EN
        tests_run++;
        if (hit_cnt !== '0 || miss_cnt !== '0) begin
            tests_failed++; $display("FAIL reset_counters got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_clean_miss();
        logic [255:0] l;
        logic [31:0]  e;
        l = mem_line(32'h40);
        l[95:64] = 32'h0000_1234;
        mem_model[32'h40] = l;
        txq.delete();
        exp_q.push_back(exp_word(32'h48));
        access(32'h48, 1'b1, 1'b0, '0, 3);
        tests_run++;
        if (acc_first_stall !== 1'b1) begin
            tests_failed++; $display("FAIL miss_first_stall got %b want 1", acc_first_stall);
        end
        tests_run++;
        if (acc_stall != 5) begin
            tests_failed++; $display("FAIL clean_miss_stall got %0d want 5", acc_stall);
        end
        tests_run++;
        if (txq.size() != 1 || txq[0].w !== 1'b0 || txq[0].a !== 32'h40) begin
            tests_failed++; $display("FAIL clean_miss_alloc got %0d txns want 1 fetch of 0x40", txq.size());
        end
        e = exp_q.pop_front();
        tests_run++;
        if (acc_rdata !== e) begin
            tests_failed++; $display("FAIL clean_miss_data got %h want %h", acc_rdata, e);
        end
    endtask

    task automatic test_write_hit();
        logic [31:0] e;
        txq.delete();
        access(32'h48, 1'b0, 1'b1, 32'hDEAD_BEEF, 1);
        tests_run++;
        if (acc_stall != 0 || txq.size() != 0) begin
            tests_failed++; $display("FAIL write_hit_stall got %0d cycles want 0", acc_stall);
        end
        tests_run++;
        if (acc_rdata !== '0) begin
            tests_failed++; $display("FAIL write_hit_p1_data got %h want 0", acc_rdata);
        end
        exp_q.push_back(exp_word(32'h48));
        access(32'h48, 1'b1, 1'b0, '0, 1);
        e = exp_q.pop_front();
        tests_run++;
        if (acc_rdata !== e || acc_stall != 0) begin
            tests_failed++; $display("FAIL write_readback got %h/%0d want %h/0", acc_rdata, acc_stall, e);
        end
    endtask

    task automatic test_dirty_eviction();
        txn_t        t0;
        txn_t        t1;
        logic [31:0] e;
        txq.delete();
        access(32'h448, 1'b1, 1'b0, '0, 2);
        tests_run++;
        if (acc_stall != 4 || txq.size() != 1) begin
            tests_failed++; $display("FAIL fill_way1 got stall=%0d txns=%0d want 4/1", acc_stall, txq.size());
        end
        txq.delete();
        exp_q.push_back(exp_word(32'h848));
        access(32'h848, 1'b1, 1'b0, '0, 2);
        e = exp_q.pop_front();
        tests_run++;
        if (acc_stall != 6) begin
            tests_failed++; $display("FAIL dirty_miss_stall got %0d want 6", acc_stall);
        end
        tests_run++;
        if (txq.size() != 2) begin
            tests_failed++; $display("FAIL dirty_txn_count got %0d want 2", txq.size());
        end else begin
            t0 = txq[0];
            t1 = txq[1];
            tests_run++;
            if (t0.w !== 1'b1 || t0.a !== 32'h40 || t0.d[95:64] !== 32'hDEAD_BEEF) begin
                tests_failed++;
                $display("FAIL wback got w=%b a=%h w2=%h want 1/40/deadbeef", t0.w, t0.a, t0.d[95:64]);
            end
            tests_run++;
            if (t1.w !== 1'b0 || t1.a !== 32'h840) begin
                tests_failed++; $display("FAIL wback_then_alloc got w=%b a=%h want 0/840", t1.w, t1.a);
            end
        end
        tests_run++;
        if (acc_rdata !== e) begin
            tests_failed++; $display("FAIL dirty_miss_data got %h want %h", acc_rdata, e);
        end
`ifdef L1_DCACHE_PERF_CNT_EN
        @(negedge clk);
        drive_idle();
        #1;
        tests_run++;
        if (miss_cnt !== 32'd3 || hit_cnt !== 32'd2) begin
            tests_failed++; $display("FAIL perf_counts got hit=%0d miss=%0d want 2/3", hit_cnt, miss_cnt);
        end
`endif
        exp_q.push_back(exp_word(32'h448));
        access(32'h448, 1'b1, 1'b0, '0, 1);
        e = exp_q.pop_front();
        tests_run++;
        if (acc_stall != 0 || acc_rdata !== e) begin
            tests_failed++; $display("FAIL way1_resident got %0d/%h want 0/%h", acc_stall, acc_rdata, e);
        end
    endtask

    task automatic test_rw_both();
        logic found;
        access(32'h48, 1'b1, 1'b0, '0, 1);
        access(32'h48, 1'b1, 1'b1, 32'hA5A5_A5A5, 1);
        tests_run++;
        if (acc_stall != 0) begin
            tests_failed++; $display("FAIL rw_both_stall got %0d want 0", acc_stall);
        end
        txq.delete();
        access(32'hC48, 1'b1, 1'b0, '0, 1);
        access(32'h1048, 1'b1, 1'b0, '0, 1);
        found = 1'b0;
        foreach (txq[i]) if (txq[i].w && txq[i].a == 32'h40 && txq[i].d[95:64] == 32'hA5A5_A5A5) found = 1'b1;
        tests_run++;
        if (found !== 1'b1) begin
            tests_failed++; $display("FAIL rw_both_dirty got no write-back of a5a5a5a5 want one at 0x40");
        end
    endtask

    task automatic test_reset_mid_alloc();
        logic        in_alloc;
        logic [31:0] e;
        do_reset();
        access(32'h48, 1'b1, 1'b0, '0, 2);
        in_alloc = 1'b0;
        for (int c = 0; c < 20 && !in_alloc; c++) begin
            @(negedge clk);
            bus.p1_addr_i = 32'h1048;
            bus.p1_read_i = 1'b1;
            #1;
            if (bus.mem_enable_o && !bus.mem_write_o) in_alloc = 1'b1;
        end
        tests_run++;
        if (in_alloc !== 1'b1) begin
            tests_failed++; $display("FAIL reach_alloc got no ALLOC want ALLOC within 20 cycles");
        end
        #1 rst = 1'b0;
        #1;
        tests_run++;
        if (bus.mem_enable_o !== 1'b0 || bus.mem_addr_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_alloc got en=%b addr=%h want 0/0", bus.mem_enable_o, bus.mem_addr_o);
        end
        bus.p1_read_i = 1'b0;
        #1;
        tests_run++;
        if (bus.p1_stall_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mid_stall got %b want 0", bus.p1_stall_o);
        end
        @(negedge clk);
        rst = 1'b1;
        golden.delete();
        exp_q.push_back(exp_word(32'h48));
        access(32'h48, 1'b1, 1'b0, '0, 2);
        e = exp_q.pop_front();
        tests_run++;
        if (acc_stall != 4 || acc_rdata !== e) begin
            tests_failed++; $display("FAIL reread_after_reset got %0d/%h want 4/%h", acc_stall, acc_rdata, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] e;
        logic        wr;
        for (int i = 0; i < 48; i++) begin
            a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 2)) << 5) |
                 (32'($urandom_range(0, 7)) << 2);
            wr = ($urandom_range(0, 2) == 0);
            if (!wr) exp_q.push_back(exp_word(a));
            access(a, !wr, wr, $urandom, $urandom_range(1, 3));
            if (!wr) begin
                e = exp_q.pop_front();
                tests_run++;
                if (acc_rdata !== e) begin
                    tests_failed++; $display("FAIL b2b_read_%0d addr=%h got %h want %h", i, a, acc_rdata, e);
                end
            end
        end
        tests_run++;
        if (acc_idle_bad != 0) begin
            tests_failed++; $display("FAIL mem_idle_zero got %0d bad cycles want 0", acc_idle_bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_dirty_eviction();
        test_rw_both();
        test_reset_mid_alloc();
        test_back_to_back();
        @(negedge clk);
        drive_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
